// File: rtl/enc_pkg.sv
// Shared constants for the quadrature encoder front end: channel-state codes,
// FSM encoding and default parameter values.
package enc_pkg;

   localparam int FILT_LEN_DEF = 8;
   localparam int POS_W_DEF    = 16;

   // Quadrature states as {A,B}; forward order is Q00 -> Q10 -> Q11 -> Q01 -> Q00.
   localparam logic [1:0] Q00 = 2'b00;
   localparam logic [1:0] Q10 = 2'b10;
   localparam logic [1:0] Q11 = 2'b11;
   localparam logic [1:0] Q01 = 2'b01;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } enc_state_t;

endpackage

// File: rtl/enc_glitch_filter.sv
// One encoder channel: two-flop synchroniser followed by a persistence filter
// that only follows the input after FILT_LEN consecutive differing cycles.
module enc_glitch_filter #(
   parameter int FILT_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filt
);

   localparam int CW = (FILT_LEN <= 1) ? 1 : $clog2(FILT_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         filt  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == filt) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // This is the FILT_LEN-th differing cycle: accept the new level.
            filt <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/enc_quad_conditioner.sv
// Quadrature encoder conditioner: filtered channels, step/direction decode and signed position.
// Define ENC_X1_MODE_EN for 1x counting (steps only on 10->11 and 11->10); default is 4x.
module enc_quad_conditioner
   import enc_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF,
   parameter int POS_W    = POS_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENC_A,
   input  logic             ENC_B,
   input  logic             CLR_POS,
   input  logic             CLR_ERR,
   output logic             STEP,
   output logic             DIR,
   output logic [POS_W-1:0] POS,
   output logic             ERR,
   output logic             READY
);

   localparam int PW = $clog2(FILT_LEN + 3);
   localparam logic [PW-1:0]           PRIME_LAST = PW'(FILT_LEN + 2);
   localparam logic [PW-1:0]           PRIME_ONE  = PW'(1);
   localparam logic signed [POS_W-1:0] POS_ONE    = POS_W'(1);

   logic                    filt_a;
   logic                    filt_b;
   logic [1:0]              cur;
   logic [1:0]              prev_q;
   logic [PW-1:0]           prime_q;
   enc_state_t              state_q;
   enc_state_t              state_d;
   logic                    run;
   logic                    fwd;
   logic                    rev;
   logic                    both;
   logic                    cnt_up;
   logic                    cnt_dn;
   logic signed [POS_W-1:0] pos_q;

   // Modular step: max+1 wraps to min and min-1 wraps to max.
   function automatic logic signed [POS_W-1:0] pos_step(input logic signed [POS_W-1:0] p,
                                                        input logic up);
      return up ? p + POS_ONE : p - POS_ONE;
   endfunction

   enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
      .clk   (CLK),
      .rst_n (RST),
      .raw   (ENC_A),
      .filt  (filt_a)
   );

   enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
      .clk   (CLK),
      .rst_n (RST),
      .raw   (ENC_B),
      .filt  (filt_b)
   );

   assign cur = {filt_a, filt_b};
   assign run = (state_q == RUN);
   assign POS = pos_q;

   always_comb begin
      fwd  = 1'b0;
      rev  = 1'b0;
      both = ((prev_q ^ cur) == 2'b11);
      case ({prev_q, cur})
         {Q00, Q10}, {Q10, Q11}, {Q11, Q01}, {Q01, Q00}: fwd = 1'b1;
         {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: rev = 1'b1;
         default: ;
      endcase
`ifdef ENC_X1_MODE_EN
      cnt_up = fwd && (prev_q == Q10);
      cnt_dn = rev && (prev_q == Q11);
`else
      cnt_up = fwd;
      cnt_dn = rev;
`endif
   end

   always_comb begin
      state_d = state_q;
      READY   = 1'b0;
      case (state_q)
         INIT: if (prime_q == PRIME_LAST) state_d = RUN;
         RUN:  READY = 1'b1;
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= INIT;
      else      state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         prev_q  <= Q00;
         prime_q <= '0;
         STEP    <= 1'b0;
         DIR     <= 1'b1;
         pos_q   <= '0;
         ERR     <= 1'b0;
      end else begin
         // prev tracks the filtered state every cycle, so an illegal jump re-bases on the new state.
         prev_q <= cur;
         if (!run) prime_q <= prime_q + PRIME_ONE;
         STEP <= run && (cnt_up || cnt_dn);
         if (run && (fwd || rev)) DIR <= fwd;
         if (CLR_POS)                      pos_q <= '0;
         else if (run && (cnt_up || cnt_dn)) pos_q <= pos_step(pos_q, cnt_up);
         ERR <= (run && both) || (ERR && !CLR_ERR);
      end
   end

endmodule

// File: tb/tb_enc_quad_conditioner.sv
// Bench for enc_quad_conditioner (FILT_LEN=8, POS_W=4): row table plus step scoreboard.
module tb_enc_quad_conditioner;

   localparam int FL = 8;
`ifdef ENC_X1_MODE_EN
   localparam bit X1 = 1'b1;
`else
   localparam bit X1 = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       ENC_A = 1'b1;
   logic       ENC_B = 1'b1;
   logic       CLR_POS = 1'b0;
   logic       CLR_ERR = 1'b0;
   logic       STEP;
   logic       DIR;
   logic [3:0] POS;
   logic       ERR;
   logic       READY;

   enc_quad_conditioner #(.FILT_LEN(FL), .POS_W(4)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .ENC_A   (ENC_A),
      .ENC_B   (ENC_B),
      .CLR_POS (CLR_POS),
      .CLR_ERR (CLR_ERR),
      .STEP    (STEP),
      .DIR     (DIR),
      .POS     (POS),
      .ERR     (ERR),
      .READY   (READY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic a;
      logic b;
      logic cp;
      logic ce;
      int   pos4;
      int   pos1;
      logic dir;
      logic err;
   } row_t;

   typedef struct {
      int   due;
      int   pos;
      logic dir;
   } exp_t;

   row_t              tbl[21];
   exp_t              sbq[$];
   int                tests = 0;
   int                fails = 0;
   int                ncyc  = 0;
   logic [1:0]        ml    = 2'b11;
   logic signed [3:0] mpos  = 4'sd0;
   logic              mdir  = 1'b1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   // One clock: sample at the falling edge and settle any step due on this cycle.
   task automatic cycle();
      exp_t e;
      @(negedge CLK);
      ncyc++;
      if (sbq.size() > 0 && sbq[0].due == ncyc) begin
         e = sbq.pop_front();
         chk("step_pulse", int'(STEP), 1);
         chk("step_pos", int'($signed(POS)), e.pos);
         chk("step_dir", int'(DIR), int'(e.dir));
      end else begin
         chk("no_step", int'(STEP), 0);
      end
   endtask

   // Reference decode of a clean level change; pushes the expected STEP if it counts.
   task automatic model(input logic [1:0] nv, input logic cp, input logic ce);
      logic f, r, cnt;
      f = (ml == 2'b00 && nv == 2'b10) || (ml == 2'b10 && nv == 2'b11) ||
          (ml == 2'b11 && nv == 2'b01) || (ml == 2'b01 && nv == 2'b00);
      r = (ml == 2'b00 && nv == 2'b01) || (ml == 2'b01 && nv == 2'b11) ||
          (ml == 2'b11 && nv == 2'b10) || (ml == 2'b10 && nv == 2'b00);
      cnt = X1 ? ((ml == 2'b10 && nv == 2'b11) || (ml == 2'b11 && nv == 2'b10)) : (f || r);
      if (f || r) mdir = f;
      if (cnt) mpos = f ? mpos + 4'sd1 : mpos - 4'sd1;
      if (cp) mpos = 4'sd0;
      if (cnt) sbq.push_back('{ncyc + FL + 3, int'(mpos), mdir});
      ml = nv;
   endtask

   task automatic run_row(input int i);
      row_t r;
      r = tbl[i];
      ENC_A = r.a;
      ENC_B = r.b;
      model({r.a, r.b}, r.cp, r.ce);
      for (int k = 1; k <= 20; k++) begin
         cycle();
         if (k == FL + 2) begin
            CLR_POS = r.cp;
            CLR_ERR = r.ce;
         end else if (k == FL + 3) begin
            CLR_POS = 1'b0;
            CLR_ERR = 1'b0;
         end
      end
      chk($sformatf("pos_row%0d", i), int'($signed(POS)), X1 ? r.pos1 : r.pos4);
      chk($sformatf("dir_row%0d", i), int'(DIR), int'(r.dir));
      chk($sformatf("err_row%0d", i), int'(ERR), int'(r.err));
   endtask

   task automatic glitch(input int len);
      ENC_A = 1'b1;
      if (len >= FL) model(2'b10, 1'b0, 1'b0);
      repeat (len) cycle();
      ENC_A = 1'b0;
      if (len >= FL) model(2'b00, 1'b0, 1'b0);
      repeat (20) cycle();
      chk($sformatf("glitch%0d_pos", len), int'($signed(POS)), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_step"},  int'(STEP), 0);
      chk({tag, "_dir"},   int'(DIR), 1);
      chk({tag, "_pos"},   int'($signed(POS)), 0);
      chk({tag, "_err"},   int'(ERR), 0);
      chk({tag, "_ready"}, int'(READY), 0);
   endtask

   task automatic prime_check(input string tag);
      repeat (FL + 2) cycle();
      chk({tag, "_ready_early"}, int'(READY), 0);
      cycle();
      chk({tag, "_ready"}, int'(READY), 1);
      chk({tag, "_err"},   int'(ERR), 0);
      chk({tag, "_pos"},   int'($signed(POS)), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      //           a     b     cp    ce    pos4 pos1 dir   err
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, -2, -1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0,  0,  0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1,  0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0,  2,  1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0,  3,  1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0,  4,  1, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0,  5,  1, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0,  6,  2, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0,  7,  2, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, -8,  2, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0,  7,  2, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, -8,  2, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, -8,  2, 1'b1, 1'b1};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, -8,  2, 1'b1, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0,  7,  1, 1'b0, 1'b0};
      tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0,  0,  0, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1,  0,  0, 1'b1, 1'b1};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1,  0,  0, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, -1,  0, 1'b0, 1'b0};
      tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0};

      repeat (3) cycle();
      check_reset_vals("reset");
      RST = 1'b1;
      prime_check("prime");

      for (int i = 0; i < 19; i++) run_row(i);

      glitch(7);
      glitch(8);
      chk("glitch8_dir", int'(DIR), 0);

      run_row(19);

      // Reverse move 01 -> 11 interrupted by reset while the filter is still counting.
      ENC_A = 1'b1;
      repeat (5) cycle();
      #3 RST = 1'b0;
      #1 check_reset_vals("midrst");
      sbq.delete();
      ml   = 2'b11;
      mpos = 4'sd0;
      mdir = 1'b1;
      repeat (3) cycle();
      RST = 1'b1;
      prime_check("reprime");

      run_row(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
